// File: rtl/div_iter_if.sv
// div_iter_if: request/result bundle for the iterative divider.
//   start        request to begin a division (sampled in IDLE or DONE)
//   dividend     unsigned dividend, captured on the accepting edge
//   divisor      unsigned divisor, captured on the accepting edge
//   quotient     registered result quotient
//   remainder    registered result remainder
//   busy         high while the divider is iterating
//   done         one-cycle pulse marking quotient/remainder valid
//   div_by_zero  set when the last accepted divisor was zero
// The master drives requests; the slave (the divider) returns results.
interface div_iter_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_iter.sv
// div_iter: unsigned restoring divider, one quotient bit per clock, MSB first.
//   clk  single clock, all state changes on the rising edge
//   rst  synchronous active-high reset, has priority over start
//   bus  div_iter_if.slave: start/dividend/divisor in,
//        quotient/remainder/busy/done/div_by_zero out (all registered)
// A normal division takes WIDTH iteration edges after the accepting edge;
// a zero divisor completes on the accepting edge itself with
// quotient = all ones and remainder = dividend.
module div_iter #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    div_iter_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COMPUTE = 2'b01,
        S_DONE    = 2'b10
    } state_t;

    typedef logic [WIDTH:0] part_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    // The dividend register shifts out dividend bits at the top while the
    // quotient bits shift in at the bottom, so after WIDTH steps it holds
    // the quotient.
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    part_t            part_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH+1:0] shifted;
    logic             qbit;
    part_t            part_d;
    logic [WIDTH-1:0] dvd_d;

    // One restoring step. The partial remainder is always below the divisor,
    // so after the shift it fits in WIDTH+1 bits; the extra top bit of
    // 'shifted' only keeps the comparison honest.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        shifted = {part_q, dvd_q[WIDTH-1]};
        qbit    = (shifted >= {2'b00, dvs_q});
        part_d  = shifted[WIDTH:0];
        if (qbit) begin
            part_d = part_t'(shifted - {2'b00, dvs_q});
        end
        dvd_d = {dvd_q[WIDTH-2:0], qbit};
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: working registers are plain flops, not a memory, so they
            // are cleared along with the outputs.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            part_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        dvd_q <= bus.dividend;
                        dvs_q <= bus.divisor;
                        if (bus.divisor == '0) begin
                            state_q     <= S_DONE;
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q <= S_COMPUTE;
                            cnt_q   <= '0;
                            part_q  <= '0;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_COMPUTE: begin
                    part_q <= part_d;
                    dvd_q  <= dvd_d;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q     <= S_DONE;
                        quotient_q  <= dvd_d;
                        remainder_q <= part_d[WIDTH-1:0];
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        dbz_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // Illegal encoding: recover to IDLE, outputs untouched.
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed self-checking bench for div_iter (WIDTH = 8).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_div_iter;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    div_iter_if #(.WIDTH(W)) bus ();

    div_iter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and let one edge accept it.
    task automatic start_op(input int a, input int b);
        bus.start    = 1'b1;
        bus.dividend = W'(a);
        bus.divisor  = W'(b);
        tick();
        bus.start = 1'b0;
    endtask

    // Called right after the accept edge. Waits (bounded) for done, checking
    // latency, busy length and that the old result holds while iterating.
    // inject >= 0 pulses a 50/5 start at that cycle of COMPUTE.
    // Returns sitting in the done cycle.
    task automatic wait_result(input string name, input int exp_lat,
                               input int exp_q, input int exp_r, input int exp_dbz,
                               input int inject);
        int          lat;
        int          busy_cnt;
        logic [W-1:0] held_q;
        logic [W-1:0] held_r;
        lat      = 0;
        busy_cnt = 0;
        held_q   = bus.quotient;
        held_r   = bus.remainder;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cnt++;
            if (bus.quotient !== held_q || bus.remainder !== held_r) begin
                check({name, "_held_during_compute"}, {bus.quotient, bus.remainder},
                      {held_q, held_r});
            end
            if (lat == inject) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd50;
                bus.divisor  = 8'd5;
            end
            tick();
            bus.start = 1'b0;
            lat++;
        end
        check({name, "_done_seen"}, 32'(bus.done), 1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy_cycles"}, busy_cnt, exp_lat);
        check({name, "_busy_at_done"}, 32'(bus.busy), 0);
        check({name, "_quotient"}, 32'(bus.quotient), exp_q);
        check({name, "_remainder"}, 32'(bus.remainder), exp_r);
        check({name, "_div_by_zero"}, 32'(bus.div_by_zero), exp_dbz);
    endtask

    // One edge after done: pulse gone, result held.
    task automatic after_done(input string name, input int exp_q, input int exp_r);
        tick();
        check({name, "_done_dropped"}, 32'(bus.done), 0);
        check({name, "_q_held"}, 32'(bus.quotient), exp_q);
        check({name, "_r_held"}, 32'(bus.remainder), exp_r);
    endtask

    initial begin
        int pulses;
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 8'd33;
        bus.divisor  = 8'd4;
        tick();
        tick();
        // Reset wins over a simultaneous start.
        check("rst_quotient", 32'(bus.quotient), 0);
        check("rst_remainder", 32'(bus.remainder), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_dbz", 32'(bus.div_by_zero), 0);
        bus.start = 1'b0;
        rst       = 1'b0;
        tick();

        // 100/7 = 14 r 2
        start_op(100, 7);
        check("d100_busy_after_accept", 32'(bus.busy), 1);
        wait_result("d100_7", 8, 14, 2, 0, -1);
        after_done("d100_7", 14, 2);

        start_op(255, 1);
        wait_result("d255_1", 8, 255, 0, 0, -1);
        after_done("d255_1", 255, 0);

        start_op(5, 9);
        wait_result("d5_9", 8, 0, 5, 0, -1);
        after_done("d5_9", 0, 5);

        start_op(0, 3);
        wait_result("d0_3", 8, 0, 0, 0, -1);
        after_done("d0_3", 0, 0);

        // Divide by zero: done right after accept, no busy.
        start_op(200, 0);
        wait_result("d200_0", 0, 255, 200, 1, -1);
        after_done("d200_0", 255, 200);
        check("d200_0_busy_after", 32'(bus.busy), 0);

        // Start during COMPUTE is ignored.
        start_op(100, 7);
        wait_result("ignore_mid", 8, 14, 2, 0, 3);
        after_done("ignore_mid", 14, 2);
        check("ignore_mid_no_restart", 32'(bus.busy), 0);

        // Back-to-back start in the DONE cycle.
        start_op(100, 7);
        wait_result("b2b_first", 8, 14, 2, 0, -1);
        start_op(81, 9);
        check("b2b_done_dropped", 32'(bus.done), 0);
        check("b2b_busy_no_idle", 32'(bus.busy), 1);
        check("b2b_old_q_held", 32'(bus.quotient), 14);
        wait_result("b2b_second", 8, 9, 0, 0, -1);
        after_done("b2b_second", 9, 0);

        // Reset in the middle of 100/7 aborts it.
        start_op(100, 7);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_quotient", 32'(bus.quotient), 0);
        check("abort_remainder", 32'(bus.remainder), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_dbz", 32'(bus.div_by_zero), 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done || bus.busy) pulses++;
            tick();
        end
        check("abort_no_activity", pulses, 0);

        start_op(9, 2);
        wait_result("d9_2", 8, 4, 1, 0, -1);
        after_done("d9_2", 4, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
